// File: rtl/seven_seg_scan_scheduler.sv
// Loads a segment-pattern message into a small buffer, then time-multiplexes it over w_digit digits, optionally scrolling.
// Outputs lag the digit index by one registered cycle; wr_ready is always high and a write during SHOW restarts loading.
module seven_seg_scan_scheduler #(
  parameter int w_digit     = 8,
  parameter int depth       = 16,
  parameter int refresh_div = 1000,
  parameter int scroll_div  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [7:0]         wr_data,
  input  logic               wr_last,
  input  logic               scroll_en,
  output logic [7:0]         abcdefgh,
  output logic [w_digit-1:0] digit,
  output logic               busy
);
  localparam int idx_w   = $clog2(w_digit);
  localparam int addr_w  = $clog2(depth);
  localparam int len_w   = addr_w + 1;
  localparam int slot_w  = $clog2(refresh_div);
  localparam int frame_w = (scroll_div > 1) ? $clog2(scroll_div) : 1;

  localparam logic [idx_w-1:0]   idx_last   = idx_w'(w_digit - 1);
  localparam logic [slot_w-1:0]  slot_last  = slot_w'(refresh_div - 1);
  localparam logic [frame_w-1:0] frame_last = frame_w'(scroll_div - 1);
  localparam logic [len_w-1:0]   len_full   = len_w'(depth);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [depth];
  logic [len_w-1:0]   len, len_nxt;
  logic [addr_w-1:0]  wr_addr;
  logic [addr_w-1:0]  offset, offset_inc;
  logic [addr_w-1:0]  ptr, ptr_inc;
  logic [idx_w-1:0]   idx;
  logic [slot_w-1:0]  slot;
  logic [frame_w-1:0] frame;
  logic               show_start;
  logic               scan;
  logic               slot_wrap, idx_wrap, frame_wrap;
  logic [7:0]         pattern;
  logic [w_digit-1:0] digit_nxt;

  assign wr_ready = 1'b1;
  assign busy     = (state == LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    wr_addr    = '0;
    show_start = 1'b0;
    case (state)
      IDLE, SHOW: begin
        if (wr_valid) begin
          len_nxt    = len_w'(1);
          state_nxt  = wr_last ? SHOW : LOAD;
          show_start = wr_last;
        end
      end
      LOAD: begin
        if (wr_valid) begin
          wr_addr = len[addr_w-1:0];
          len_nxt = len + len_w'(1);
          // A full buffer closes the message even without wr_last.
          if (wr_last || (len_nxt == len_full)) begin
            state_nxt  = SHOW;
            show_start = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A write in SHOW preempts the scan so nothing stale is driven afterwards.
  assign scan       = (state == SHOW) && !wr_valid;
  assign slot_wrap  = (slot == slot_last);
  assign idx_wrap   = (idx == idx_last);
  assign frame_wrap = (frame == frame_last);
  assign offset_inc = ((len_w'(offset) + len_w'(1)) == len) ? '0 : offset + addr_w'(1);
  assign ptr_inc    = ((len_w'(ptr) + len_w'(1)) == len) ? '0 : ptr + addr_w'(1);
  assign digit_nxt  = {{(w_digit-1){1'b0}}, 1'b1} << idx;

  // ptr tracks (offset + idx) mod len incrementally so no divider is needed.
  always_comb begin
    pattern = 8'h00;
    if (scroll_en) begin
      pattern = mem[ptr];
    end else if (len_w'(idx) < len) begin
      pattern = mem[addr_w'(idx)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_valid) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= '0;
      idx      <= '0;
      slot     <= '0;
      frame    <= '0;
      offset   <= '0;
      ptr      <= '0;
      abcdefgh <= 8'h00;
      digit    <= '0;
    end else begin
      len      <= len_nxt;
      abcdefgh <= scan ? pattern : 8'h00;
      digit    <= scan ? digit_nxt : '0;
      if (show_start) begin
        idx    <= '0;
        slot   <= '0;
        frame  <= '0;
        offset <= '0;
        ptr    <= '0;
      end else if (scan) begin
        if (!slot_wrap) begin
          slot <= slot + slot_w'(1);
        end else begin
          slot <= '0;
          if (!idx_wrap) begin
            idx <= idx + idx_w'(1);
            ptr <= ptr_inc;
          end else begin
            idx <= '0;
            if (scroll_en && frame_wrap) begin
              frame  <= '0;
              offset <= offset_inc;
              ptr    <= offset_inc;
            end else begin
              if (scroll_en) begin
                frame <= frame + frame_w'(1);
              end
              ptr <= offset;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_scheduler.sv
// Bench for seven_seg_scan_scheduler: vector table, corner sequences and randomized traffic against an arithmetic model.
module tb_seven_seg_scan_scheduler;
  localparam int WD    = 4;
  localparam int DEPTH = 8;
  localparam int RD    = 2;
  localparam int SD    = 1;

  localparam logic [7:0] LF = 8'h8E;
  localparam logic [7:0] LP = 8'hCE;
  localparam logic [7:0] LG = 8'hBC;
  localparam logic [7:0] LA = 8'hEE;

  logic       clk = 1'b0;
  logic       rst, wr_valid, wr_ready, wr_last, scroll_en, busy;
  logic [7:0] wr_data, abcdefgh;
  logic [3:0] digit;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_scheduler #(
    .w_digit(WD), .depth(DEPTH), .refresh_div(RD), .scroll_div(SD)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .scroll_en(scroll_en),
    .abcdefgh(abcdefgh), .digit(digit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: mode 0 idle, 1 load, 2 show; ms counts scan cycles since SHOW entry.
  logic [7:0] mbuf [DEPTH];
  int         mlen = 0, ms = 0, mmode = 0;
  logic [7:0] e_seg = 8'h00;
  logic [3:0] e_dig = 4'h0;

  function automatic void model_step(bit r, bit wv, logic [7:0] d, bit last, bit scr);
    int ix, fr, off;
    e_seg = 8'h00;
    e_dig = 4'h0;
    if (r) begin
      mmode = 0; mlen = 0; ms = 0;
      return;
    end
    if (mmode == 2 && !wv) begin
      ix    = (ms / RD) % WD;
      fr    = ms / (RD * WD);
      off   = scr ? (fr / SD) % mlen : 0;
      e_dig = 4'(1 << ix);
      if (scr) e_seg = mbuf[(off + ix) % mlen];
      else if (ix < mlen) e_seg = mbuf[ix];
      ms++;
    end
    if (wv) begin
      if (mmode != 1) begin
        mbuf[0] = d; mlen = 1; ms = 0;
        mmode = last ? 2 : 1;
      end else begin
        mbuf[mlen] = d; mlen++;
        if (last || mlen == DEPTH) begin
          mmode = 2; ms = 0;
        end
      end
    end
  endfunction

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic cyc(input bit r, input bit wv, input logic [7:0] d, input bit last, input bit scr);
    rst = r; wr_valid = wv; wr_data = d; wr_last = last; scroll_en = scr;
    @(posedge clk);
    model_step(r, wv, d, last, scr);
    @(negedge clk);
    chk("model_seg", abcdefgh, e_seg);
    chk("model_digit", 8'(digit), 8'(e_dig));
    chk("model_busy", 8'(busy), 8'(mmode == 1));
    chk("wr_ready", 8'(wr_ready), 8'h01);
  endtask

  task automatic expect_out(input string nm, input bit b, input logic [3:0] dg, input logic [7:0] sg);
    chk({nm, "_busy"}, 8'(busy), 8'(b));
    chk({nm, "_digit"}, 8'(digit), 8'(dg));
    chk({nm, "_seg"}, abcdefgh, sg);
  endtask

  typedef struct {
    bit         r;
    bit         wv;
    logic [7:0] d;
    bit         last;
    bit         e_busy;
    logic [3:0] e_dig;
    logic [7:0] e_seg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit wv, input logic [7:0] d, input bit last,
                     input bit b, input logic [3:0] dg, input logic [7:0] sg);
    vec_t v;
    v.r = r; v.wv = wv; v.d = d; v.last = last;
    v.e_busy = b; v.e_dig = dg; v.e_seg = sg;
    vq.push_back(v);
  endtask

  int         tn  [4];
  logic [3:0] tdg [4];
  logic [7:0] tsg [4];
  logic [7:0] seq9 [5];
  logic [3:0] dig9 [5];
  bit         scr_r;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0; scroll_en = 1'b0;

    // F,P,G,A then a full scan cycle
    add(1,0,8'h00,0, 0,4'h0,8'h00);
    add(0,1,LF,0, 1,4'h0,8'h00);
    add(0,1,LP,0, 1,4'h0,8'h00);
    add(0,1,LG,0, 1,4'h0,8'h00);
    add(0,1,LA,1, 0,4'h0,8'h00);
    add(0,0,0,0, 0,4'h1,LF); add(0,0,0,0, 0,4'h1,LF);
    add(0,0,0,0, 0,4'h2,LP); add(0,0,0,0, 0,4'h2,LP);
    add(0,0,0,0, 0,4'h4,LG); add(0,0,0,0, 0,4'h4,LG);
    add(0,0,0,0, 0,4'h8,LA); add(0,0,0,0, 0,4'h8,LA);
    add(0,0,0,0, 0,4'h1,LF); add(0,0,0,0, 0,4'h1,LF);
    // short message F,P: digits 2..3 blank but still enabled
    add(0,1,LF,0, 1,4'h0,8'h00);
    add(0,1,LP,1, 0,4'h0,8'h00);
    add(0,0,0,0, 0,4'h1,LF); add(0,0,0,0, 0,4'h1,LF);
    add(0,0,0,0, 0,4'h2,LP); add(0,0,0,0, 0,4'h2,LP);
    add(0,0,0,0, 0,4'h4,8'h00); add(0,0,0,0, 0,4'h4,8'h00);
    add(0,0,0,0, 0,4'h8,8'h00); add(0,0,0,0, 0,4'h8,8'h00);
    add(0,0,0,0, 0,4'h1,LF);
    // reset mid-LOAD after two symbols; the write under reset is dropped
    add(0,1,LF,0, 1,4'h0,8'h00);
    add(0,1,LP,0, 1,4'h0,8'h00);
    add(1,1,LG,0, 0,4'h0,8'h00);
    add(0,0,0,0, 0,4'h0,8'h00); add(0,0,0,0, 0,4'h0,8'h00); add(0,0,0,0, 0,4'h0,8'h00);
    add(0,1,LA,1, 0,4'h0,8'h00);
    add(0,0,0,0, 0,4'h1,LA); add(0,0,0,0, 0,4'h1,LA);
    add(0,0,0,0, 0,4'h2,8'h00);

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].wv, vq[i].d, vq[i].last, 1'b0);
      expect_out($sformatf("tbl%0d", i), vq[i].e_busy, vq[i].e_dig, vq[i].e_seg);
    end

    // scrolling: offset advances every frame and wraps after len frames
    tn[0] = 9;  tdg[0] = 4'h1; tsg[0] = LP;
    tn[1] = 11; tdg[1] = 4'h2; tsg[1] = LG;
    tn[2] = 25; tdg[2] = 4'h1; tsg[2] = LA;
    tn[3] = 33; tdg[3] = 4'h1; tsg[3] = LF;
    cyc(1,0,8'h00,0,1);
    cyc(0,1,LF,0,1); cyc(0,1,LP,0,1); cyc(0,1,LG,0,1); cyc(0,1,LA,1,1);
    for (int n = 1; n <= 34; n++) begin
      cyc(0,0,8'h00,0,1);
      for (int k = 0; k < 4; k++)
        if (tn[k] == n) expect_out($sformatf("scroll_n%0d", n), 1'b0, tdg[k], tsg[k]);
    end

    // nine writes without wr_last: the 8th fills the buffer, the 9th restarts
    cyc(1,0,8'h00,0,0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0,1,8'(i),0,0);
      chk($sformatf("fill_busy%0d", i), 8'(busy), (i < 8) ? 8'h01 : 8'h00);
    end
    cyc(0,0,8'h00,0,0);
    expect_out("full_s0", 1'b0, 4'h1, 8'h01);
    cyc(0,1,8'h09,0,0);
    expect_out("ninth", 1'b1, 4'h0, 8'h00);
    cyc(0,1,8'h0A,1,0);
    expect_out("tenth", 1'b0, 4'h0, 8'h00);
    seq9[0] = 8'h09; seq9[1] = 8'h09; seq9[2] = 8'h0A; seq9[3] = 8'h0A; seq9[4] = 8'h00;
    dig9[0] = 4'h1;  dig9[1] = 4'h1;  dig9[2] = 4'h2;  dig9[3] = 4'h2;  dig9[4] = 4'h4;
    for (int i = 0; i < 5; i++) begin
      cyc(0,0,8'h00,0,0);
      expect_out($sformatf("restart%0d", i), 1'b0, dig9[i], seq9[i]);
    end

    // write landing on a slot wrap that would also advance idx
    cyc(1,0,8'h00,0,0);
    cyc(0,1,LF,0,0); cyc(0,1,LP,0,0); cyc(0,1,LG,0,0); cyc(0,1,LA,1,0);
    cyc(0,0,8'h00,0,0); cyc(0,0,8'h00,0,0); cyc(0,0,8'h00,0,0);
    expect_out("pre_wrap", 1'b0, 4'h2, LP);
    cyc(0,1,8'h3C,0,0);
    expect_out("wrap_write", 1'b1, 4'h0, 8'h00);
    cyc(0,0,8'h00,0,0);
    expect_out("wrap_hold1", 1'b1, 4'h0, 8'h00);
    cyc(0,0,8'h00,0,0);
    expect_out("wrap_hold2", 1'b1, 4'h0, 8'h00);

    // randomized traffic; scroll_en only changes alongside a write so SHOW runs see it constant
    scr_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit r_i, wv_i, last_i;
      logic [7:0] d_i;
      r_i    = ($urandom_range(0, 199) == 0);
      wv_i   = (mmode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      last_i = ($urandom_range(0, 4) == 0);
      d_i    = 8'($urandom);
      if (wv_i) scr_r = 1'($urandom_range(0, 1));
      cyc(r_i, wv_i, d_i, last_i, scr_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_scheduler.md
SEVEN_SEG_SCAN_SCHEDULER -- requirements
Module: seven_seg_scan_scheduler

Interface
REQ-001 SHALL have parameter w_digit, default 8, number of display digits (2..8).
REQ-002 SHALL have parameter depth, default 16, message buffer entries (power of 2, at least w_digit).
REQ-003 SHALL have parameter refresh_div, default 1000, clock cycles each digit is lit (at least 2).
REQ-004 SHALL have parameter scroll_div, default 50, full scan frames per scroll step (at least 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-007 SHALL have port wr_valid, input, 1, a message symbol is offered.
REQ-008 SHALL have port wr_ready, output, 1, the block accepts a symbol.
REQ-009 SHALL have port wr_data, input, 8, segment pattern in abcdefgh order, 1 = segment lit.
REQ-010 SHALL have port wr_last, input, 1, the offered symbol ends the message.
REQ-011 SHALL have port scroll_en, input, 1, enables rotation of the message.
REQ-012 SHALL have port abcdefgh, output, 8, registered segment drive.
REQ-013 SHALL have port digit, output, w_digit, registered one-hot digit enable, active-high.
REQ-014 SHALL have port busy, output, 1, high while a message is being loaded.

Function
REQ-015 SHALL implement states IDLE (no message; outputs dark), LOAD (accepting symbols) and SHOW (scanning the message).
REQ-016 SHALL complete a write when wr_valid and wr_ready are both high in the same cycle; wr_ready SHALL be 1 in every state.
REQ-017 In IDLE or SHOW, a completed write SHALL start a new message:
- store the symbol at address 0;
- set len to 1;
- enter LOAD, or enter SHOW directly if wr_last is 1.
REQ-018 In LOAD, each completed write SHALL:
- store the symbol at address len;
- increment len.
REQ-019 LOAD SHALL exit to SHOW after a write that has wr_last=1 or that makes len equal depth; the symbol that makes len equal depth SHALL be the final symbol, whatever wr_last is.
REQ-020 busy SHALL be 1 exactly while the state is LOAD.
REQ-021 While in LOAD, abcdefgh and digit SHALL be 0.
REQ-022 In SHOW, a slot counter SHALL count 0..refresh_div-1; on wrap it SHALL advance the digit index idx from 0 to w_digit-1, wrapping to 0.
REQ-023 Each wrap of idx from w_digit-1 to 0 SHALL end one frame.
REQ-024 When scroll_en=1, a frame counter SHALL count 0..scroll_div-1 and, on wrap, advance offset = (offset+1) mod len.
REQ-025 When scroll_en=0, the frame counter and offset SHALL hold their values.
REQ-026 The pattern for digit idx SHALL be:
- buf[(offset+idx) mod len] if scroll_en=1;
- buf[idx] if scroll_en=0 and idx < len;
- 0 (blank) if scroll_en=0 and idx >= len.
REQ-027 In SHOW, outputs SHALL update one cycle after idx changes: digit = 1<<idx and abcdefgh = the pattern for idx.
REQ-028 Entry to SHOW SHALL clear idx, offset and both counters; the first SHOW cycle SHALL assert digit bit 0 within 1 cycle.
REQ-029 A write accepted in SHOW SHALL take priority over the scan advance in the same cycle; outputs SHALL be 0 from the next cycle.
REQ-030 The modulo in REQ-026 SHALL use the len of the message held in SHOW; len SHALL never be 0 in SHOW.

Reset
REQ-031 While rst=1, the block SHALL force:
- state IDLE, len 0, idx 0, offset 0, all counters 0;
- abcdefgh 0, digit 0, busy 0.
REQ-032 Reset SHALL not clear buffer contents, but those contents SHALL be unobservable until a new message has been written.
REQ-033 Reset asserted during LOAD or SHOW SHALL abort the operation at the next edge; writes in that cycle SHALL be ignored.

Verification (w_digit=4, depth=8, refresh_div=2, scroll_div=1)
REQ-034 Bench SHALL check: write F,P,G,A (A with last) -> busy high for 3 cycles; then digit 0001/0010/0100/1000 with abcdefgh 8E/CE/BC/EE, each held 2 cycles, repeating.
REQ-035 Bench SHALL check: message F,P with scroll_en=0 -> digits 0..1 show 8E/CE; digits 2..3 show abcdefgh 00 with the digit bit still asserted.
REQ-036 Bench SHALL check: F,P,G,A with scroll_en=1 -> second frame digit 0 shows CE; fifth frame digit 0 shows 8E again (offset wraps).
REQ-037 Bench SHALL check: 9 writes with wr_last never set -> SHOW after the 8th write; the 9th write starts a new message of len 1.
REQ-038 Bench SHALL check: rst pulsed mid-LOAD after 2 symbols -> next cycle busy 0 and outputs 0; idle with no display until a new message arrives.
REQ-039 Bench SHALL check: a write in SHOW in the same cycle as a slot wrap -> LOAD entered, outputs 0 the next cycle, and no stale digit lit.
